// File: rtl/round_robin_arbiter_n_req_pkg.sv
`default_nettype none
// ============================================================================
// Module   : round_robin_arbiter_n_req_pkg
// Purpose  : Shared helper for the N-requester round-robin arbiter.
//            Provides the modulo-N increment that sets the scan start index.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package round_robin_arbiter_n_req_pkg;

  // (idx + 1) mod n, written as an explicit compare so that non-power-of-2
  // requester counts wrap correctly.
  function automatic int unsigned wrap_inc(input int unsigned idx,
                                           input int unsigned n);
    if ((idx + 1) >= n) begin
      return 0;
    end
    return idx + 1;
  endfunction

endpackage : round_robin_arbiter_n_req_pkg
`default_nettype wire

// File: rtl/rr_priority_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_pick
// Purpose  : Combinational rotating-priority picker. The request vector is
//            rotated so that slot 0 corresponds to 'start', a fixed-priority
//            encoder finds the lowest set slot, and the slot is mapped back to
//            its absolute requester index.
// Ports    : req   [N]          - request vector
//            start [clog2(N)]   - index that has highest priority (< N)
//            grant [N]          - one-hot grant, zero when no request
//            idx   [clog2(N)]   - granted index, zero when no request
//            any                - at least one request is set
// Revision : 1.0 - initial release
// ============================================================================
module rr_priority_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] start,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);
  // One extra bit so start + offset (< 2N) never overflows before the wrap.
  localparam logic [IW:0] C_N = (IW + 1)'(N);

  logic [N-1:0] w_rot;
  logic [IW:0]  w_pos [N];

  // Slot i of the rotated vector is requester (start + i) mod N.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
      logic [IW:0] w_sum;
      assign w_sum      = {1'b0, start} + (IW + 1)'(gi);
      assign w_pos[gi]  = (w_sum >= C_N) ? (w_sum - C_N) : w_sum;
      assign w_rot[gi]  = req[w_pos[gi][IW-1:0]];
    end
  endgenerate

  // Fixed-priority encode on the rotated vector; walking downward lets the
  // lowest set slot overwrite the others. Mapping through w_pos is the
  // rotate-back step.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        any = 1'b1;
        idx = w_pos[i][IW-1:0];
      end
    end
  end

  generate
    for (genvar gj = 0; gj < N; gj++) begin : g_grant
      assign grant[gj] = any && (idx == IW'(gj));
    end
  endgenerate

endmodule : rr_priority_pick
`default_nettype wire

// File: rtl/round_robin_arbiter_n_req.sv
`default_nettype none
// ============================================================================
// Module   : round_robin_arbiter_n_req
// Purpose  : N-requester round-robin arbiter with a bounded grant-hold burst.
//            The grant is combinational from the requests; a registered owner
//            index and hold counter decide who is favoured next.
// Ports    : clk               - clock, rising edge
//            rst               - asynchronous reset, active low
//            requests    [N]   - level-sensitive request per requester
//            grants      [N]   - one-hot grant or zero
//            grant_valid       - OR of grants
//            grant_idx   [clog2(N)] - granted index, zero when no grant
// Revision : 1.0 - initial release
// ============================================================================
module round_robin_arbiter_n_req
  import round_robin_arbiter_n_req_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         requests,
  output logic [N-1:0]         grants,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int IW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] C_MAX_HOLD = HW'(MAX_HOLD);
  localparam logic [HW-1:0] C_HOLD_ONE = HW'(1);

  logic          r_last_valid;
  logic [IW-1:0] r_last_idx;
  logic [HW-1:0] r_hold_cnt;

  logic          w_keep;
  logic [IW-1:0] w_start;
  logic [N-1:0]  w_pick_grant;
  logic [IW-1:0] w_pick_idx;
  logic          w_pick_any;
  logic [N-1:0]  w_keep_grant;
  logic [N-1:0]  w_sel_grant;
  logic [IW-1:0] w_sel_idx;
  logic          w_active;

  // A zero hold count means the chain was broken by an idle cycle (or never
  // started), so the owner only competes through the normal scan.
  assign w_keep = r_last_valid
               && requests[r_last_idx]
               && (r_hold_cnt != '0)
               && (r_hold_cnt < C_MAX_HOLD);

  assign w_start = r_last_valid ? IW'(wrap_inc(int'(r_last_idx), N)) : '0;

  rr_priority_pick #(
    .N (N)
  ) u_pick (
    .req   (requests),
    .start (w_start),
    .grant (w_pick_grant),
    .idx   (w_pick_idx),
    .any   (w_pick_any)
  );

  assign w_keep_grant = N'(1) << r_last_idx;
  assign w_sel_grant  = w_keep ? w_keep_grant : w_pick_grant;
  assign w_sel_idx    = w_keep ? r_last_idx   : w_pick_idx;

  // Outputs are gated by rst so they drop the moment reset asserts.
  assign w_active    = rst && w_pick_any;
  assign grants      = w_active ? w_sel_grant : '0;
  assign grant_valid = w_active;
  assign grant_idx   = w_active ? w_sel_idx   : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_valid <= 1'b0;
      r_last_idx   <= '0;
      r_hold_cnt   <= '0;
    end else if (!w_pick_any) begin
      r_hold_cnt   <= '0;
    end else if (w_keep) begin
      r_hold_cnt   <= r_hold_cnt + C_HOLD_ONE;
    end else begin
      // New owner, or the sole requester restarting after its burst ran out.
      r_last_valid <= 1'b1;
      r_last_idx   <= w_sel_idx;
      r_hold_cnt   <= C_HOLD_ONE;
    end
  end

endmodule : round_robin_arbiter_n_req
`default_nettype wire
